// File: rtl/ca2_pkg.sv
// Shared encodings for the multi-cycle core: opcodes, ALU codes, datapath
// mux selects and the sequencing FSM state set.
package ca2_pkg;

  localparam logic [6:0] OP_R    = 7'd0;
  localparam logic [6:0] OP_LW   = 7'd1;
  localparam logic [6:0] OP_ADDI = 7'd2;
  localparam logic [6:0] OP_XORI = 7'd3;
  localparam logic [6:0] OP_ORI  = 7'd4;
  localparam logic [6:0] OP_SLTI = 7'd5;
  localparam logic [6:0] OP_JALR = 7'd6;
  localparam logic [6:0] OP_SW   = 7'd7;
  localparam logic [6:0] OP_JAL  = 7'd8;
  localparam logic [6:0] OP_BEQ  = 7'd9;
  localparam logic [6:0] OP_BNE  = 7'd10;
  localparam logic [6:0] OP_BLT  = 7'd11;
  localparam logic [6:0] OP_BGE  = 7'd12;
  localparam logic [6:0] OP_LUI  = 7'd13;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;

  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JALR_TGT, S_JUMP, S_LINK_WB, S_LUI
  } state_t;

  // What kind of ALU operation the current state needs.
  typedef enum logic [1:0] {
    AC_ADD, AC_SUB, AC_FUNCT, AC_IMM
  } alu_class_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU class plus opcode/funct3 onto the 3-bit ALU operation.
module alu_decoder
  import ca2_pkg::*;
(
  input  alu_class_t cls,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  output logic [2:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    unique case (cls)
      AC_ADD:   alu_op = ALU_ADD;
      AC_SUB:   alu_op = ALU_SUB;
      AC_FUNCT: alu_op = f3;
      AC_IMM: begin
        case (op)
          OP_XORI: alu_op = ALU_XOR;
          OP_ORI:  alu_op = ALU_OR;
          OP_SLTI: alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      default:  alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Sequencing FSM for the multi-cycle core: one state register and a
// next-state/output block driving every datapath enable and select.
module multi_cycle_controller
  import ca2_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic       zero,
  input  logic       sign_bit,
  output logic       pc_we,
  output logic       ir_we,
  output logic       old_pc_we,
  output logic       adr_sel,
  output logic       mem_we,
  output logic       reg_we,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [2:0] imm_sel,
  output logic [2:0] alu_op,
  output logic [1:0] result_sel,
  output logic       fetch
);

  logic [STATE_W-1:0] state_q, state_d;
  state_t             state, next;
  alu_class_t         alu_cls;
  logic               pc_we_raw, ir_we_raw, old_pc_we_raw, mem_we_raw, reg_we_raw;
  logic               is_branch_op, take;

  assign state = state_t'(state_q[$bits(state_t)-1:0]);
  assign state_d = STATE_W'(next);

  always_ff @(posedge clk) begin
    if (rst) state_q <= STATE_W'(S_FETCH);
    else     state_q <= state_d;
  end

  assign is_branch_op = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BGE);
  assign take = ((op == OP_BEQ) &&  zero) || ((op == OP_BNE) && !zero) ||
                ((op == OP_BLT) &&  sign_bit) || ((op == OP_BGE) && !sign_bit);

  always_comb begin
    next          = S_FETCH;
    pc_we_raw     = 1'b0;
    ir_we_raw     = 1'b0;
    old_pc_we_raw = 1'b0;
    mem_we_raw    = 1'b0;
    reg_we_raw    = 1'b0;
    adr_sel       = 1'b0;
    alu_a_sel     = A_PC;
    alu_b_sel     = B_RS2;
    imm_sel       = IMM_I;
    result_sel    = RES_ALUOUT;
    alu_cls       = AC_ADD;
    fetch         = 1'b0;
    unique case (state)
      S_FETCH: begin
        ir_we_raw     = 1'b1;
        old_pc_we_raw = 1'b1;
        pc_we_raw     = 1'b1;
        alu_b_sel     = B_FOUR;
        result_sel    = RES_ALU;
        fetch         = 1'b1;
        next          = S_DECODE;
      end
      S_DECODE: begin
        alu_a_sel = A_OLDPC;
        alu_b_sel = B_IMM;
        if (is_branch_op)     imm_sel = IMM_B;
        else if (op == OP_JAL) imm_sel = IMM_J;
        case (op)
          OP_R:                                next = S_EXEC_R;
          OP_ADDI, OP_XORI, OP_ORI, OP_SLTI:   next = S_EXEC_I;
          OP_LW, OP_SW:                        next = S_MEM_ADR;
          OP_BEQ, OP_BNE, OP_BLT, OP_BGE:      next = S_BRANCH;
          OP_JAL:                              next = S_JUMP;
          OP_JALR:                             next = S_JALR_TGT;
          OP_LUI:                              next = S_LUI;
          default:                             next = S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        alu_a_sel = A_RS1;
        alu_cls   = AC_FUNCT;
        next      = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_IMM;
        alu_cls   = AC_IMM;
        next      = S_ALU_WB;
      end
      S_ALU_WB, S_LINK_WB: reg_we_raw = 1'b1;
      S_MEM_ADR: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_IMM;
        if (op == OP_SW) begin
          imm_sel = IMM_S;
          next    = S_MEM_WR;
        end else begin
          next    = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        adr_sel = 1'b1;
        next    = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we_raw = 1'b1;
        result_sel = RES_MDR;
      end
      S_MEM_WR: begin
        adr_sel    = 1'b1;
        mem_we_raw = 1'b1;
      end
      // Only Mealy output: branch taken depends on the live ALU flags.
      S_BRANCH: begin
        alu_a_sel = A_RS1;
        alu_cls   = AC_SUB;
        pc_we_raw = take;
      end
      S_JALR_TGT: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_IMM;
        next      = S_JUMP;
      end
      S_JUMP: begin
        pc_we_raw = 1'b1;
        alu_a_sel = A_OLDPC;
        alu_b_sel = B_FOUR;
        next      = S_LINK_WB;
      end
      S_LUI: begin
        imm_sel    = IMM_U;
        result_sel = RES_IMM;
        reg_we_raw = 1'b1;
      end
      default: next = S_FETCH;
    endcase
  end

  assign pc_we     = pc_we_raw     & ~rst;
  assign ir_we     = ir_we_raw     & ~rst;
  assign old_pc_we = old_pc_we_raw & ~rst;
  assign mem_we    = mem_we_raw    & ~rst;
  assign reg_we    = reg_we_raw    & ~rst;

  alu_decoder u_alu_decoder (
    .cls    (alu_cls),
    .op     (op),
    .f3     (f3),
    .alu_op (alu_op)
  );

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Sequencing FSM for the multi-cycle build of the core. It executes the same custom 7-bit opcode ISA on a datapath that has a shared instruction/data memory, IR/OldPC/MDR/ALUOut registers and a single ALU. Each instruction is broken into 3–5 states, and the block drives every datapath enable and mux select from the current state, `op`, `f3`, `zero` and `sign_bit`.

## Interface
Parameters:
- `STATE_W`, default 4: width of the state register.

Ports:
- `clk`  in  1: single clock; all state changes occur on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `op`  in  7: opcode field from the IR.
- `f3`  in  3: funct3 from the IR.
- `zero`  in  1: ALU result == 0.
- `sign_bit`  in  1: ALU result bit 31.
- `pc_we`  out  1: PC load.
- `ir_we`  out  1: IR load.
- `old_pc_we`  out  1: OldPC load.
- `adr_sel`  out  1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_we`  out  1: memory write.
- `reg_we`  out  1: register-file write.
- `alu_a_sel`  out  2: 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_b_sel`  out  2: 00 = rs2, 01 = imm, 10 = constant 4.
- `imm_sel`  out  3: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `alu_op`  out  3: 000 = ADD, 001 = SUB, 010 = AND, 011 = OR, 100 = XOR, 101 = SLT.
- `result_sel`  out  2: 00 = ALUOut, 01 = MDR, 10 = ALU direct, 11 = imm.
- `fetch`  out  1: high in FETCH; used for instruction counting.

## Operation
**Opcodes:** R = 0, LW = 1, ADDI = 2, XORI = 3, ORI = 4, SLTI = 5, JALR = 6, SW = 7, JAL = 8, BEQ = 9, BNE = 10, BLT = 11, BGE = 12, LUI = 13.

**Default output values:** all enables 0; all selects 0, except `alu_op` = ADD. In each state, listed outputs are asserted and all others take their defaults.

**States:**
- **FETCH:** `ir_we`, `old_pc_we`, `pc_we`; A = PC, B = 4, ADD, `result_sel` = 10. Next: DECODE.
- **DECODE:** A = OldPC, B = imm, ADD. `imm_sel` = B for branches, J for JAL, otherwise I. ALUOut captures the branch/jump target. Next state by opcode:
  - R → EXEC_R
  - ADDI / XORI / ORI / SLTI → EXEC_I
  - LW / SW → MEM_ADR
  - BEQ..BGE → BRANCH
  - JAL → JUMP
  - JALR → JALR_TGT
  - LUI → LUI
  - any other opcode → FETCH (NOP)
- **EXEC_R:** A = rs1, B = rs2, `alu_op` = `f3`. Next: ALU_WB.
- **EXEC_I:** A = rs1, B = imm (I). `alu_op`: ADDI = ADD, XORI = XOR, ORI = OR, SLTI = SLT. Next: ALU_WB.
- **ALU_WB:** `reg_we`, `result_sel` = 00. Next: FETCH.
- **MEM_ADR:** A = rs1, B = imm, ADD; `imm_sel` = S for SW, I for LW. Next: MEM_RD for LW, MEM_WR for SW.
- **MEM_RD:** `adr_sel` = 1. Next: MEM_WB.
- **MEM_WB:** `reg_we`, `result_sel` = 01. Next: FETCH.
- **MEM_WR:** `adr_sel` = 1, `mem_we`. Next: FETCH.
- **BRANCH:** A = rs1, B = rs2, SUB, `result_sel` = 00.
  - `pc_we` = (BEQ & `zero`) | (BNE & !`zero`) | (BLT & `sign_bit`) | (BGE & !`sign_bit`).
  - This is the only Mealy output.
  - Next: FETCH.
- **JALR_TGT:** A = rs1, B = imm (I), ADD. Next: JUMP.
- **JUMP:** `pc_we`, `result_sel` = 00 (target). In the same cycle A = OldPC, B = 4, ADD, so ALUOut captures the link value. Next: LINK_WB.
- **LINK_WB:** `reg_we`, `result_sel` = 00. Next: FETCH.
- **LUI:** `imm_sel` = U, `result_sel` = 11, `reg_we`. Next: FETCH.

**Read-before-write:** JALR with rd == rs1 is correct, because rs1 is read in JALR_TGT, before the write in LINK_WB.

## Timing
- **Reset:**
  - `rst` high at an edge puts the state in FETCH, from any state, including mid-instruction.
  - While `rst` is high, `pc_we`, `ir_we`, `old_pc_we`, `mem_we` and `reg_we` are forced to 0.
  - The first fetch occurs in the first cycle with `rst` low.
- **Cycles per instruction:** R / I-ALU = 4, LW = 5, SW = 4, branch = 3, JAL = 4, JALR = 5, LUI = 3, unknown = 2.
- **Output timing:** outputs are combinational from the state register (plus `zero` / `sign_bit` in BRANCH). There are no registered outputs and no added latency.
- **Write exclusivity:** at most one of `mem_we` / `reg_we` is asserted per cycle. `pc_we` and `reg_we` are never asserted together.

## Structure
- **Shared package `ca2_pkg`:** opcode constants, ALU code constants, the `imm_sel` / `result_sel` / `alu_a_sel` / `alu_b_sel` encodings, and the state enum.
- **Sub-module `alu_decoder`:** combinational; maps (state class, `op`, `f3`) to `alu_op`.
- The FSM has a single state register plus a next-state/output block.

## Test plan
- **Reset:** hold `rst` 2 cycles with `op` = 0 → all write enables 0; `fetch` = 1 in the first cycle after release; DECODE in the next cycle.
- **R-type:** `op` = 0, `f3` = 100 → sequence FETCH, DECODE, EXEC_R (`alu_op` = 100), ALU_WB (`reg_we` = 1, `result_sel` = 00) → FETCH; 4 cycles total.
- **LW then SW:**
  - LW: 5 cycles; `adr_sel` = 1 in MEM_RD; `result_sel` = 01 with `reg_we` in MEM_WB.
  - SW: `mem_we` high exactly 1 cycle; `imm_sel` = 001 in MEM_ADR.
- **Branches:** in BRANCH, `pc_we` = 1 for:
  - BEQ with `zero` = 1
  - BNE with `zero` = 0
  - BLT with `sign_bit` = 1
  - BGE with `sign_bit` = 0
  
  Each complementary input gives `pc_we` = 0.
- **JALR:** sequence DECODE → JALR_TGT → JUMP (`pc_we` = 1, A = 01, B = 10) → LINK_WB (`reg_we` = 1).
- **Reset mid-LW and unknown opcode:**
  - `rst` asserted in MEM_RD → next state FETCH; no `reg_we` pulse.
  - `op` = 7'h7F → DECODE → FETCH; no enables asserted.
